dbgu_burst: RTL
===============

// Module: dbgu_burst
// PURPOSE
//  Parametrised successor debug unit: byte-stream command engine between a UART (valid/ready bytes)
//  and the 6502 core/memory. 3-byte command frames; variable-length responses from a buffer;
//  burst memory read, 16-bit cycle-run counter, PC breakpoint, inter-byte timeout.
// PARAMETERS
//  ADDR_W      16    memory address width (<=16; args carry 16 bits, upper bits dropped)
//  MAX_BURST   16    response buffer depth in bytes (>=8); also burst-read clamp
//  CYC_W       16    run-cycle counter width
//  RX_TIMEOUT  1000  clk cycles of rx silence that discard a partial frame
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       asynchronous, active-high reset
//  rx_valid     in   1       rx_data valid this cycle (1-clk pulse per byte)
//  rx_data      in   8       received byte
//  tx_valid     out  1       tx_data valid; held until tx_ready
//  tx_ready     in   1       UART accepts byte when tx_valid&tx_ready
//  tx_data      out  8       byte to send
//  val_PC       in   16      CPU program counter
//  val_IR/A/X/Y/S in 8 each  CPU registers
//  cpu_clk      out  1       gated CPU clock
//  cpu_n_reset  out  1       CPU reset, active-low
//  mem_adr      out  ADDR_W  memory address (= adr_ptr)
//  mem_wdata    out  8       write data
//  mem_rdata    in   8       read data, valid 1 clk after read strobe
//  mem_rw       out  1       1=read, 0=write
//  mem_op       out  1       1-clk memory strobe
//  busy         out  1       state != S_RX
//  err_overrun  out  1       sticky: rx byte dropped while busy
// BEHAVIOUR
//  Reset: tx_valid=0, tx_data=0, cpu_clk=0, cpu_n_reset=1, mem_op=0, mem_rw=1, mem_wdata=0,
//   adr_ptr=0, busy=0, err_overrun=0, bp disabled, state S_RX, frame index 0.
//  States: S_RX -> S_EXEC -> (S_MEM | S_RUN | S_TX) -> S_TX -> S_RX.
//  S_RX: frame = {op, a0, a1}; 3rd byte -> S_EXEC next clk. Timer reloads on each byte; expiry with
//   index 1..2 resets index to 0, no response. rx_valid outside S_RX: byte dropped, err_overrun=1.
//  Commands (ACK=0xA5, NAK=0x5A, all responses loaded to buffer then S_TX):
//   0x01 SET_ADDR  adr_ptr={a1,a0}       -> ACK
//   0x03 GET_ADDR                        -> adr_ptr lo, hi
//   0x04 WRITE     one strobe mem_rw=0, mem_wdata=a0, then adr_ptr+1 -> ACK
//   0x05 READ_BURST n=a0; 0->1, >MAX_BURST->MAX_BURST; n strobes, one per 2 clk, adr_ptr+1 each
//                   -> n data bytes in address order
//   0x10 GET_REGS                        -> A,X,Y,S,IR,PC lo,PC hi
//   0x20 RUN       cycles={a1,a0} truncated to CYC_W; 0 -> ACK immediately
//   0x21 CPU_RESET cpu_n_reset=0 for 4 clk, then 1 -> ACK
//   other opcodes -> NAK
//  adr_ptr wraps 2^ADDR_W-1 -> 0 silently.
//  S_RUN: cpu_clk toggles every clk; count decrements on each 1->0 edge of cpu_clk;
//   count 0 -> cpu_clk stays 0 -> ACK. cpu_clk never left high on exit.
//  S_TX: bytes sent in order, index advances on tx_valid&tx_ready; tx_valid drops the clk after
//   the last handshake; state returns to S_RX.
//  Reset mid-operation: everything aborts to reset values; partial response lost.
// CONFIGURATION
//  DBGU_BREAKPOINT_EN defined: adds 0x30 SET_BP (bp={a1,a0}, enabled) -> ACK and 0x31 CLR_BP -> ACK.
//   In S_RUN, at each 1->0 cpu_clk edge, if enabled and val_PC==bp: stop, respond 0xB0, PC lo, PC hi.
//   Checked before count decrement; bp hit on final cycle reports 0xB0.
//  Not defined: 0x30/0x31 -> NAK; no PC comparator or bp register synthesised.
// TESTING
//  SET_ADDR 01 34 12, GET_ADDR 03 00 00 -> A5, then 34 12
//  SET_ADDR FFFF; WRITE 04 77 00 -> one mem_op with mem_rw=0, mem_adr=FFFF, wdata=77; adr_ptr=0000
//  Memory preloaded 0010..0012=AA BB CC; SET_ADDR 0010; READ_BURST 05 03 00 -> AA BB CC
//  READ_BURST n=0 -> 1 byte; n=FF -> MAX_BURST bytes
//  RUN 20 05 00 -> exactly 5 cpu_clk falling edges, then A5; RUN 0 -> A5 with no cpu_clk edge
//  Send 2 bytes, wait RX_TIMEOUT+1 clk, send 03 00 00 -> adr_ptr bytes only
//  Opcode 7F -> 5A; byte during S_TX -> dropped, err_overrun=1
//  With DBGU_BREAKPOINT_EN: SET_BP 0200; PC reaches 0200 at cycle 3; RUN 10 -> B0 00 02

Source files
------------

// File: rtl/dbgu_burst.sv
// dbgu_burst: byte-stream debug command engine between a UART and a 6502 core/memory.
//
// Each command is a 3-byte frame {op, a0, a1} received on rx_*. The response is built in a
// byte buffer and then streamed out on tx_*. Supported operations are address pointer
// set/get, single write, burst read, register snapshot, counted CPU run and CPU reset. A
// partial frame is dropped after RX_TIMEOUT idle clocks.
//
// Optional feature: define DBGU_BREAKPOINT_EN to add the PC breakpoint commands (0x30/0x31)
// and the breakpoint check during a run.
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   rx_valid_i, rx_data_i    incoming bytes (1-clk pulse per byte)
//   tx_valid_o, tx_ready_i,
//   tx_data_o                outgoing bytes, valid held until ready
//   val_pc_i, val_*_i        CPU register snapshot inputs
//   cpu_clk_o, cpu_n_reset_o gated CPU clock, active-low CPU reset
//   mem_*                    memory strobe interface, read data valid 1 clk after strobe
//   busy_o                   engine not waiting for command bytes
//   err_overrun_o            sticky: a byte arrived while busy and was dropped
module dbgu_burst #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned RX_TIMEOUT = 1000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  input  logic [15:0]       val_pc_i,
  input  logic [7:0]        val_ir_i,
  input  logic [7:0]        val_a_i,
  input  logic [7:0]        val_x_i,
  input  logic [7:0]        val_y_i,
  input  logic [7:0]        val_s_i,
  output logic              cpu_clk_o,
  output logic              cpu_n_reset_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_rw_o,
  output logic              mem_op_o,
  output logic              busy_o,
  output logic              err_overrun_o
);

  localparam int unsigned IdxW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam int unsigned TmrW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

  localparam logic [7:0] Ack   = 8'hA5;
  localparam logic [7:0] Nak   = 8'h5A;
  localparam logic [7:0] BpHit = 8'hB0;

  typedef enum logic [2:0] {StRx, StExec, StMem, StRun, StCpuRst, StTx} state_e;

  state_e            state_q;
  logic [1:0]        frm_idx_q;
  logic [7:0]        op_q, a0_q, a1_q;
  logic [TmrW-1:0]   tmr_q;
  logic [ADDR_W-1:0] adr_ptr_q;
  logic [7:0]        rsp_q [MAX_BURST];
  logic [CntW-1:0]   rsp_len_q;
  logic [IdxW-1:0]   tx_idx_q;
  logic [IdxW-1:0]   rd_cnt_q;
  logic [CntW-1:0]   burst_n_q;
  logic              rd_phase_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [1:0]        rst_cnt_q;
  logic              tx_valid_q, cpu_clk_q, cpu_n_reset_q, mem_op_q, mem_rw_q, err_overrun_q;
  logic [7:0]        tx_data_q, mem_wdata_q;
`ifdef DBGU_BREAKPOINT_EN
  logic [15:0]       bp_q;
  logic              bp_en_q;
`endif

  logic [15:0]      arg16, adr16;
  logic [CYC_W-1:0] cyc_arg;
  logic [CntW-1:0]  burst_n;
  logic [IdxW-1:0]  tx_idx_nxt;
  logic             tx_last, rd_last;

  always_comb begin
    arg16      = {a1_q, a0_q};
    adr16      = 16'(adr_ptr_q);
    cyc_arg    = CYC_W'(arg16);
    tx_idx_nxt = tx_idx_q + IdxW'(1);
    tx_last    = (CntW'(tx_idx_q) + CntW'(1)) == rsp_len_q;
    rd_last    = (CntW'(rd_cnt_q) + CntW'(1)) == burst_n_q;
    // Burst length clamp: 0 reads one byte, anything above the buffer depth is capped.
    if (a0_q == 8'h00) begin
      burst_n = CntW'(1);
    end else if (32'(a0_q) > MAX_BURST) begin
      burst_n = CntW'(MAX_BURST);
    end else begin
      burst_n = CntW'(a0_q);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StRx;
      frm_idx_q     <= '0;
      op_q          <= '0;
      a0_q          <= '0;
      a1_q          <= '0;
      tmr_q         <= '0;
      adr_ptr_q     <= '0;
      for (int i = 0; i < MAX_BURST; i++) rsp_q[i] <= '0;
      rsp_len_q     <= '0;
      tx_idx_q      <= '0;
      rd_cnt_q      <= '0;
      burst_n_q     <= '0;
      rd_phase_q    <= 1'b0;
      cyc_q         <= '0;
      rst_cnt_q     <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cpu_clk_q     <= 1'b0;
      cpu_n_reset_q <= 1'b1;
      mem_op_q      <= 1'b0;
      mem_rw_q      <= 1'b1;
      mem_wdata_q   <= '0;
      err_overrun_q <= 1'b0;
`ifdef DBGU_BREAKPOINT_EN
      bp_q          <= '0;
      bp_en_q       <= 1'b0;
`endif
    end else begin
      if (rx_valid_i && (state_q != StRx)) err_overrun_q <= 1'b1;

      unique case (state_q)
        StRx: begin
          if (rx_valid_i) begin
            tmr_q <= TmrW'(RX_TIMEOUT);
            unique case (frm_idx_q)
              2'd0:    begin op_q <= rx_data_i; frm_idx_q <= 2'd1; end
              2'd1:    begin a0_q <= rx_data_i; frm_idx_q <= 2'd2; end
              default: begin a1_q <= rx_data_i; frm_idx_q <= 2'd0; state_q <= StExec; end
            endcase
          end else if (frm_idx_q != 2'd0) begin
            if (tmr_q == '0) frm_idx_q <= 2'd0;
            else             tmr_q     <= tmr_q - TmrW'(1);
          end
        end

        StExec: begin
          // Single-byte responses default to ACK; multi-byte commands override below.
          rsp_q[0]  <= Ack;
          rsp_len_q <= CntW'(1);
          state_q   <= StTx;
          case (op_q)
            8'h01: adr_ptr_q <= ADDR_W'(arg16);
            8'h03: begin
              rsp_q[0]  <= adr16[7:0];
              rsp_q[1]  <= adr16[15:8];
              rsp_len_q <= CntW'(2);
            end
            8'h04: begin
              mem_op_q    <= 1'b1;
              mem_rw_q    <= 1'b0;
              mem_wdata_q <= a0_q;
              state_q     <= StMem;
            end
            8'h05: begin
              burst_n_q  <= burst_n;
              rd_cnt_q   <= '0;
              rd_phase_q <= 1'b0;
              mem_op_q   <= 1'b1;
              mem_rw_q   <= 1'b1;
              state_q    <= StMem;
            end
            8'h10: begin
              rsp_q[0]  <= val_a_i;
              rsp_q[1]  <= val_x_i;
              rsp_q[2]  <= val_y_i;
              rsp_q[3]  <= val_s_i;
              rsp_q[4]  <= val_ir_i;
              rsp_q[5]  <= val_pc_i[7:0];
              rsp_q[6]  <= val_pc_i[15:8];
              rsp_len_q <= CntW'(7);
            end
            8'h20: begin
              if (cyc_arg != '0) begin
                cyc_q   <= cyc_arg;
                state_q <= StRun;
              end
            end
            8'h21: begin
              cpu_n_reset_q <= 1'b0;
              rst_cnt_q     <= 2'd3;
              state_q       <= StCpuRst;
            end
`ifdef DBGU_BREAKPOINT_EN
            8'h30: begin
              bp_q    <= arg16;
              bp_en_q <= 1'b1;
            end
            8'h31: bp_en_q <= 1'b0;
`endif
            default: rsp_q[0] <= Nak;
          endcase
        end

        StMem: begin
          mem_op_q <= 1'b0;
          if (!mem_rw_q) begin
            mem_rw_q  <= 1'b1;
            adr_ptr_q <= adr_ptr_q + ADDR_W'(1);
            rsp_q[0]  <= Ack;
            rsp_len_q <= CntW'(1);
            state_q   <= StTx;
          end else if (!rd_phase_q) begin
            // Strobe cycle; the data comes back during the next one.
            rd_phase_q <= 1'b1;
          end else begin
            rsp_q[rd_cnt_q] <= mem_rdata_i;
            adr_ptr_q       <= adr_ptr_q + ADDR_W'(1);
            rd_phase_q      <= 1'b0;
            if (rd_last) begin
              rsp_len_q <= burst_n_q;
              state_q   <= StTx;
            end else begin
              rd_cnt_q <= rd_cnt_q + IdxW'(1);
              mem_op_q <= 1'b1;
            end
          end
        end

        StRun: begin
          if (!cpu_clk_q) begin
            cpu_clk_q <= 1'b1;
          end else begin
            // Falling CPU clock edge: breakpoint first, then the cycle count.
            cpu_clk_q <= 1'b0;
`ifdef DBGU_BREAKPOINT_EN
            if (bp_en_q && (val_pc_i == bp_q)) begin
              rsp_q[0]  <= BpHit;
              rsp_q[1]  <= val_pc_i[7:0];
              rsp_q[2]  <= val_pc_i[15:8];
              rsp_len_q <= CntW'(3);
              state_q   <= StTx;
            end else begin
`else
            begin
`endif
              cyc_q <= cyc_q - CYC_W'(1);
              if (cyc_q == CYC_W'(1)) begin
                rsp_q[0]  <= Ack;
                rsp_len_q <= CntW'(1);
                state_q   <= StTx;
              end
            end
          end
        end

        StCpuRst: begin
          if (rst_cnt_q == 2'd0) begin
            cpu_n_reset_q <= 1'b1;
            rsp_q[0]      <= Ack;
            rsp_len_q     <= CntW'(1);
            state_q       <= StTx;
          end else begin
            rst_cnt_q <= rst_cnt_q - 2'd1;
          end
        end

        StTx: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= rsp_q[tx_idx_q];
          end else if (tx_ready_i) begin
            if (tx_last) begin
              tx_valid_q <= 1'b0;
              tx_idx_q   <= '0;
              state_q    <= StRx;
            end else begin
              tx_idx_q  <= tx_idx_nxt;
              tx_data_q <= rsp_q[tx_idx_nxt];
            end
          end
        end

        default: state_q <= StRx;
      endcase
    end
  end

  assign tx_valid_o    = tx_valid_q;
  assign tx_data_o     = tx_data_q;
  assign cpu_clk_o     = cpu_clk_q;
  assign cpu_n_reset_o = cpu_n_reset_q;
  assign mem_adr_o     = adr_ptr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_rw_o      = mem_rw_q;
  assign mem_op_o      = mem_op_q;
  assign busy_o        = (state_q != StRx);
  assign err_overrun_o = err_overrun_q;

endmodule
